// File: rtl/hbexec_wide_pkg.sv
// Shared command/response codes, FSM states and special payloads for the
// hbexec_wide command-to-wishbone executor.
package hbexec_wide_pkg;

  localparam logic [1:0] CMD_RD   = 2'b00;
  localparam logic [1:0] CMD_WR   = 2'b01;
  localparam logic [1:0] CMD_ADDR = 2'b10;

  localparam logic [1:0] RSP_RD      = 2'b00;
  localparam logic [1:0] RSP_WR      = 2'b01;
  localparam logic [1:0] RSP_ADDR    = 2'b10;
  localparam logic [1:0] RSP_SPECIAL = 2'b11;

  localparam int unsigned SPECIAL_ERROR = 0;
  localparam int unsigned SPECIAL_RESET = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/hbexec_wide_rsp.sv
// Response former: turns ack, error, set-address and post-reset events into a
// registered single-cycle response word.
module hbexec_wide_rsp
  import hbexec_wide_pkg::*;
#(
  parameter int AW = 30,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ack_evt,
  input  logic          ack_we,
  input  logic [DW-1:0] ack_data,
  input  logic          err_evt,
  input  logic          addr_evt,
  input  logic [AW-1:0] addr,
  output logic          rsp_stb,
  output logic [DW+1:0] rsp_word
);

  logic reset_pend;

  // reset_pend survives reset as 1 so the first live clock announces the reset.
  // Error outranks an ack arriving in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reset_pend <= 1'b1;
      rsp_stb    <= 1'b0;
      rsp_word   <= '0;
    end else begin
      reset_pend <= 1'b0;
      rsp_stb    <= err_evt | ack_evt | addr_evt | reset_pend;
      if (err_evt)
        rsp_word <= {RSP_SPECIAL, DW'(SPECIAL_ERROR)};
      else if (ack_evt)
        rsp_word <= ack_we ? {RSP_WR, {DW{1'b0}}} : {RSP_RD, ack_data};
      else if (addr_evt)
        rsp_word <= {RSP_ADDR, DW'(addr)};
      else if (reset_pend)
        rsp_word <= {RSP_SPECIAL, DW'(SPECIAL_RESET)};
    end
  end

endmodule

// File: rtl/hbexec_wide.sv
// Command-word driven wishbone master. Define HBEXEC_WIDE_BURST_EN to enable
// pipelined read bursts; otherwise every read is a single request.
module hbexec_wide
  import hbexec_wide_pkg::*;
#(
  parameter int AW      = 30,
  parameter int DW      = 32,
  parameter int LGBURST = 4
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_cmd_stb,
  input  logic [DW+1:0]   i_cmd_word,
  output logic            o_cmd_busy,
  output logic            o_rsp_stb,
  output logic [DW+1:0]   o_rsp_word,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [AW-1:0]   o_wb_addr,
  output logic [DW-1:0]   o_wb_data,
  output logic [DW/8-1:0] o_wb_sel,
  input  logic            i_wb_ack,
  input  logic            i_wb_stall,
  input  logic            i_wb_err,
  input  logic [DW-1:0]   i_wb_data
);

`ifdef HBEXEC_WIDE_BURST_EN
  localparam int CW = LGBURST + 1;
`else
  localparam int CW = 1;
`endif

  state_t        state;
  logic          fixed_addr;
  logic          final_busy;
  logic [CW-1:0] req_left;
  logic [CW-1:0] pending;
  logic [CW-1:0] left_nxt;
  logic [CW-1:0] pend_nxt;
  logic [CW-1:0] rd_count;
  logic [1:0]    cmd_type;
  logic          accept;
  logic          issue;
  logic          ack;
  logic          err;
  logic          done;
  logic          unused_bits;

  assign cmd_type    = i_cmd_word[DW+1:DW];
  assign o_cmd_busy  = (state != IDLE) || final_busy;
  assign accept      = i_cmd_stb && !o_cmd_busy;
  assign issue       = o_wb_stb && !i_wb_stall;
  assign err         = o_wb_cyc && i_wb_err;
  assign ack         = o_wb_cyc && i_wb_ack && !i_wb_err;
  assign left_nxt    = req_left - CW'(issue);
  assign pend_nxt    = pending + CW'(issue) - CW'(ack);
  assign done        = (left_nxt == '0) && (pend_nxt == '0);
  assign o_wb_sel    = '1;
  assign unused_bits = ^i_cmd_word;

`ifdef HBEXEC_WIDE_BURST_EN
  assign rd_count = CW'(i_cmd_word[LGBURST-1:0]) + CW'(1);
`else
  assign rd_count = CW'(1);
`endif

  // Bus sequencer: IDLE decodes commands, REQ issues strobes, WAIT drains acks.
  // final_busy holds off new commands while the last response is on the wire.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= IDLE;
      o_wb_cyc   <= 1'b0;
      o_wb_stb   <= 1'b0;
      o_wb_we    <= 1'b0;
      o_wb_addr  <= '0;
      o_wb_data  <= '0;
      fixed_addr <= 1'b0;
      req_left   <= '0;
      pending    <= '0;
      final_busy <= 1'b0;
    end else begin
      final_busy <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            case (cmd_type)
              CMD_ADDR: begin
                o_wb_addr  <= i_cmd_word[AW-1:0];
                fixed_addr <= i_cmd_word[DW-1];
              end
              CMD_RD: begin
                state    <= REQ;
                o_wb_cyc <= 1'b1;
                o_wb_stb <= 1'b1;
                o_wb_we  <= 1'b0;
                req_left <= rd_count;
              end
              CMD_WR: begin
                state     <= REQ;
                o_wb_cyc  <= 1'b1;
                o_wb_stb  <= 1'b1;
                o_wb_we   <= 1'b1;
                o_wb_data <= i_cmd_word[DW-1:0];
                req_left  <= CW'(1);
              end
              default: ;
            endcase
          end
        end
        default: begin
          if (err) begin
            state      <= IDLE;
            o_wb_cyc   <= 1'b0;
            o_wb_stb   <= 1'b0;
            o_wb_we    <= 1'b0;
            req_left   <= '0;
            pending    <= '0;
            final_busy <= 1'b1;
          end else begin
            req_left <= left_nxt;
            pending  <= pend_nxt;
            if (issue && !fixed_addr)
              o_wb_addr <= o_wb_addr + AW'(1);
            if (done) begin
              state      <= IDLE;
              o_wb_cyc   <= 1'b0;
              o_wb_stb   <= 1'b0;
              o_wb_we    <= 1'b0;
              final_busy <= 1'b1;
            end else if (left_nxt == '0) begin
              state    <= WAIT;
              o_wb_stb <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  hbexec_wide_rsp #(
    .AW(AW),
    .DW(DW)
  ) u_rsp (
    .clk     (i_clk),
    .rst     (i_reset),
    .ack_evt (ack),
    .ack_we  (o_wb_we),
    .ack_data(i_wb_data),
    .err_evt (err),
    .addr_evt(accept && (cmd_type == CMD_ADDR)),
    .addr    (i_cmd_word[AW-1:0]),
    .rsp_stb (o_rsp_stb),
    .rsp_word(o_rsp_word)
  );

endmodule

// File: tb/tb_hbexec_wide.sv
// Directed bench for hbexec_wide: a command vector table plus hand-written
// burst, fixed-address, error and reset sequences against a simple slave model.
module tb_hbexec_wide;
  import hbexec_wide_pkg::*;

  localparam int AW = 30;
  localparam int DW = 32;
  localparam logic [31:0] DATA_BASE = 32'hA5A5_0000;

  logic            i_clk;
  logic            i_reset;
  logic            i_cmd_stb;
  logic [DW+1:0]   i_cmd_word;
  logic            o_cmd_busy;
  logic            o_rsp_stb;
  logic [DW+1:0]   o_rsp_word;
  logic            o_wb_cyc;
  logic            o_wb_stb;
  logic            o_wb_we;
  logic [AW-1:0]   o_wb_addr;
  logic [DW-1:0]   o_wb_data;
  logic [DW/8-1:0] o_wb_sel;
  logic            i_wb_ack;
  logic            i_wb_stall;
  logic            i_wb_err;
  logic [DW-1:0]   i_wb_data;

  hbexec_wide dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_cmd_stb (i_cmd_stb),
    .i_cmd_word(i_cmd_word),
    .o_cmd_busy(o_cmd_busy),
    .o_rsp_stb (o_rsp_stb),
    .o_rsp_word(o_rsp_word),
    .o_wb_cyc  (o_wb_cyc),
    .o_wb_stb  (o_wb_stb),
    .o_wb_we   (o_wb_we),
    .o_wb_addr (o_wb_addr),
    .o_wb_data (o_wb_data),
    .o_wb_sel  (o_wb_sel),
    .i_wb_ack  (i_wb_ack),
    .i_wb_stall(i_wb_stall),
    .i_wb_err  (i_wb_err),
    .i_wb_data (i_wb_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad = 0;

  logic [DW+1:0] rsp_q[$];
  logic [AW-1:0] req_addr[$];
  logic          req_we[$];
  logic [DW-1:0] req_data[$];
  logic [3:0]    req_sel[$];
  int            due_q[$];
  int            cyc_n = 0;
  int            req_cnt = 0;
  int            ack_cnt = 0;
  int            lat = 3;
  int            stall_req = -1;
  int            err_ack = -1;
  bit            stalled = 0;

  typedef struct {
    logic [DW+1:0] cmd;
    bit            has_rsp;
    logic [DW+1:0] exp_rsp;
    bit            has_bus;
    logic [AW-1:0] exp_addr;
    logic          exp_we;
    logic [DW-1:0] exp_data;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs[NV];

  function automatic logic [DW+1:0] mk(input logic [1:0] t, input logic [DW-1:0] p);
    return {t, p};
  endfunction

  function automatic logic [63:0] getRsp(input int i);
    if (i < rsp_q.size()) return 64'(rsp_q[i]);
    return 64'hDEAD_BEEF_0BAD_F00D;
  endfunction

  function automatic logic [63:0] getAddr(input int i);
    if (i < req_addr.size()) return 64'(req_addr[i]);
    return 64'hDEAD_BEEF_0BAD_F00D;
  endfunction

  // Slave model: optional one-shot stall, fixed ack latency, optional error
  // in place of a chosen ack; also captures every response pulse.
  initial begin
    i_wb_ack = 1'b0;
    i_wb_stall = 1'b0;
    i_wb_err = 1'b0;
    i_wb_data = '0;
    forever begin
      @(negedge i_clk);
      cyc_n++;
      if (o_rsp_stb) rsp_q.push_back(o_rsp_word);
      i_wb_ack = 1'b0;
      i_wb_err = 1'b0;
      i_wb_stall = 1'b0;
      i_wb_data = '0;
      if (!o_wb_cyc) begin
        due_q.delete();
      end else begin
        if (o_wb_stb && req_cnt == stall_req && !stalled) begin
          i_wb_stall = 1'b1;
          stalled = 1'b1;
        end
        if (o_wb_stb && !i_wb_stall) begin
          req_addr.push_back(o_wb_addr);
          req_we.push_back(o_wb_we);
          req_data.push_back(o_wb_data);
          req_sel.push_back(o_wb_sel);
          due_q.push_back(cyc_n + lat);
          req_cnt++;
        end
        if (due_q.size() > 0 && due_q[0] == cyc_n) begin
          void'(due_q.pop_front());
          if (ack_cnt == err_ack) begin
            i_wb_err = 1'b1;
          end else begin
            i_wb_ack = 1'b1;
            i_wb_data = DATA_BASE + 32'(ack_cnt);
          end
          ack_cnt++;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clearScoreboard();
    rsp_q.delete();
    req_addr.delete();
    req_we.delete();
    req_data.delete();
    req_sel.delete();
    req_cnt = 0;
    ack_cnt = 0;
    stalled = 1'b0;
  endtask

  task automatic applyStimulus(input logic [DW+1:0] w);
    int n = 0;
    @(negedge i_clk);
    #1;
    while (o_cmd_busy && n < 200) begin
      @(negedge i_clk);
      #1;
      n++;
    end
    i_cmd_stb = 1'b1;
    i_cmd_word = w;
    @(negedge i_clk);
    #1;
    i_cmd_stb = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    do begin
      @(negedge i_clk);
      #1;
      n++;
    end while ((o_wb_cyc || o_cmd_busy) && n < 300);
    checkOutput({name, "_idle"}, 64'(o_wb_cyc || o_cmd_busy), 64'd0);
    repeat (2) begin
      @(negedge i_clk);
      #1;
    end
  endtask

  initial begin
    int n;
    vecs[0]  = '{mk(CMD_ADDR, 32'h100),        1, mk(RSP_ADDR, 32'h100),      0, 30'h0,        1'b0, 32'h0};
    vecs[1]  = '{mk(CMD_WR, 32'hDEADBEEF),     1, mk(RSP_WR, 32'h0),          1, 30'h100,      1'b1, 32'hDEADBEEF};
    vecs[2]  = '{mk(CMD_RD, 32'h0),            1, mk(RSP_RD, DATA_BASE),      1, 30'h101,      1'b0, 32'h0};
    vecs[3]  = '{mk(CMD_ADDR, 32'h3FFFFFFF),   1, mk(RSP_ADDR, 32'h3FFFFFFF), 0, 30'h0,        1'b0, 32'h0};
    vecs[4]  = '{mk(CMD_WR, 32'h12345678),     1, mk(RSP_WR, 32'h0),          1, 30'h3FFFFFFF, 1'b1, 32'h12345678};
    vecs[5]  = '{mk(CMD_RD, 32'h0),            1, mk(RSP_RD, DATA_BASE),      1, 30'h0,        1'b0, 32'h0};
    vecs[6]  = '{mk(2'b11, 32'hFFFFFFFF),      0, mk(2'b00, 32'h0),           0, 30'h0,        1'b0, 32'h0};
    vecs[7]  = '{mk(CMD_ADDR, 32'h80000055),   1, mk(RSP_ADDR, 32'h55),       0, 30'h0,        1'b0, 32'h0};
    vecs[8]  = '{mk(CMD_WR, 32'h000000AA),     1, mk(RSP_WR, 32'h0),          1, 30'h55,       1'b1, 32'h000000AA};
    vecs[9]  = '{mk(CMD_RD, 32'h0),            1, mk(RSP_RD, DATA_BASE),      1, 30'h55,       1'b0, 32'h0};
    vecs[10] = '{mk(CMD_ADDR, 32'h101),        1, mk(RSP_ADDR, 32'h101),      0, 30'h0,        1'b0, 32'h0};

    i_reset = 1'b1;
    i_cmd_stb = 1'b0;
    i_cmd_word = '0;
    repeat (3) @(negedge i_clk);
    #1;
    checkOutput("reset_cyc", 64'(o_wb_cyc), 64'd0);
    checkOutput("reset_stb", 64'(o_wb_stb), 64'd0);
    checkOutput("reset_rsp_stb", 64'(o_rsp_stb), 64'd0);
    checkOutput("reset_busy", 64'(o_cmd_busy), 64'd0);
    clearScoreboard();
    i_reset = 1'b0;
    waitIdle("reset_release");
    checkOutput("reset_rsp_count", 64'(rsp_q.size()), 64'd1);
    checkOutput("reset_rsp_word", getRsp(0), 64'(mk(RSP_SPECIAL, 32'h1)));

    for (int i = 0; i < NV; i++) begin
      clearScoreboard();
      applyStimulus(vecs[i].cmd);
      checkOutput($sformatf("v%0d_cyc_next", i), 64'(o_wb_cyc), 64'(vecs[i].has_bus));
      waitIdle($sformatf("v%0d", i));
      checkOutput($sformatf("v%0d_rsp_count", i), 64'(rsp_q.size()), 64'(vecs[i].has_rsp));
      if (vecs[i].has_rsp)
        checkOutput($sformatf("v%0d_rsp_word", i), getRsp(0), 64'(vecs[i].exp_rsp));
      checkOutput($sformatf("v%0d_req_count", i), 64'(req_cnt), 64'(vecs[i].has_bus));
      if (vecs[i].has_bus && req_cnt > 0) begin
        checkOutput($sformatf("v%0d_addr", i), 64'(req_addr[0]), 64'(vecs[i].exp_addr));
        checkOutput($sformatf("v%0d_we", i), 64'(req_we[0]), 64'(vecs[i].exp_we));
        checkOutput($sformatf("v%0d_sel", i), 64'(req_sel[0]), 64'hF);
        if (vecs[i].exp_we)
          checkOutput($sformatf("v%0d_data", i), 64'(req_data[0]), 64'(vecs[i].exp_data));
      end
    end

`ifdef HBEXEC_WIDE_BURST_EN
    // Burst of 4 from 0x101 with one stall on the second request.
    clearScoreboard();
    stall_req = 1;
    applyStimulus(mk(CMD_RD, 32'd3));
    n = 0;
    do begin
      @(posedge i_clk);
      n++;
    end while (!(i_wb_ack && ack_cnt == 4) && n < 100);
    checkOutput("burst_ack4_seen", 64'(n < 100), 64'd1);
    #1;
    checkOutput("burst_cyc_after_ack4", 64'(o_wb_cyc), 64'd0);
    checkOutput("burst_busy_final_rsp", 64'(o_cmd_busy), 64'd1);
    waitIdle("burst");
    stall_req = -1;
    checkOutput("burst_req_count", 64'(req_cnt), 64'd4);
    checkOutput("burst_rsp_count", 64'(rsp_q.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("burst_addr%0d", k), getAddr(k), 64'(30'h101 + 30'(k)));
      checkOutput($sformatf("burst_rsp%0d", k), getRsp(k), 64'(mk(RSP_RD, DATA_BASE + 32'(k))));
    end
    clearScoreboard();
    applyStimulus(mk(CMD_RD, 32'd0));
    waitIdle("burst_next");
    checkOutput("burst_next_addr", getAddr(0), 64'h105);

    // Fixed-address burst of 3 at 0x20.
    applyStimulus(mk(CMD_ADDR, 32'h80000020));
    waitIdle("fixed_addr_cmd");
    clearScoreboard();
    applyStimulus(mk(CMD_RD, 32'd2));
    waitIdle("fixed");
    checkOutput("fixed_req_count", 64'(req_cnt), 64'd3);
    checkOutput("fixed_rsp_count", 64'(rsp_q.size()), 64'd3);
    for (int k = 0; k < 3; k++)
      checkOutput($sformatf("fixed_addr%0d", k), getAddr(k), 64'h20);

    // Error on the second ack of a burst of 8.
    applyStimulus(mk(CMD_ADDR, 32'h200));
    waitIdle("err_addr_cmd");
    clearScoreboard();
    err_ack = 1;
    applyStimulus(mk(CMD_RD, 32'd7));
    n = 0;
    do begin
      @(posedge i_clk);
      n++;
    end while (!i_wb_err && n < 100);
    checkOutput("err_seen", 64'(n < 100), 64'd1);
    #1;
    checkOutput("err_cyc_next", 64'(o_wb_cyc), 64'd0);
    checkOutput("err_stb_next", 64'(o_wb_stb), 64'd0);
    checkOutput("err_busy", 64'(o_cmd_busy), 64'd1);
    checkOutput("err_rsp_stb", 64'(o_rsp_stb), 64'd1);
    checkOutput("err_rsp_live", 64'(o_rsp_word), 64'(mk(RSP_SPECIAL, 32'h0)));
    waitIdle("err");
    err_ack = -1;
    checkOutput("err_rsp_count", 64'(rsp_q.size()), 64'd2);
    checkOutput("err_rsp0", getRsp(0), 64'(mk(RSP_RD, DATA_BASE)));
    checkOutput("err_rsp1", getRsp(1), 64'(mk(RSP_SPECIAL, 32'h0)));
    clearScoreboard();
    applyStimulus(mk(CMD_WR, 32'h0BADF00D));
    waitIdle("err_after");
    checkOutput("err_after_req_count", 64'(req_cnt), 64'd1);
    checkOutput("err_after_rsp", getRsp(0), 64'(mk(RSP_WR, 32'h0)));
`else
    // Count field is ignored: exactly one request and one response.
    applyStimulus(mk(CMD_ADDR, 32'h40));
    waitIdle("single_addr_cmd");
    clearScoreboard();
    applyStimulus(mk(CMD_RD, 32'd7));
    waitIdle("single");
    checkOutput("single_req_count", 64'(req_cnt), 64'd1);
    checkOutput("single_rsp_count", 64'(rsp_q.size()), 64'd1);
    checkOutput("single_addr", getAddr(0), 64'h40);
    checkOutput("single_rsp", getRsp(0), 64'(mk(RSP_RD, DATA_BASE)));
`endif

    // Reset in the middle of an outstanding read.
    applyStimulus(mk(CMD_ADDR, 32'h0));
    waitIdle("rst_addr_cmd");
    clearScoreboard();
    lat = 20;
    applyStimulus(mk(CMD_RD, 32'd15));
    checkOutput("midrst_cyc_before", 64'(o_wb_cyc), 64'd1);
    #2;
    i_reset = 1'b1;
    #1;
    checkOutput("midrst_cyc", 64'(o_wb_cyc), 64'd0);
    checkOutput("midrst_stb", 64'(o_wb_stb), 64'd0);
    checkOutput("midrst_rsp_stb", 64'(o_rsp_stb), 64'd0);
    repeat (2) @(negedge i_clk);
    #1;
    clearScoreboard();
    lat = 3;
    i_reset = 1'b0;
    repeat (5) @(negedge i_clk);
    #1;
    checkOutput("midrst_rsp_count", 64'(rsp_q.size()), 64'd1);
    checkOutput("midrst_rsp_word", getRsp(0), 64'(mk(RSP_SPECIAL, 32'h1)));
    checkOutput("midrst_req_count", 64'(req_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hbexec_wide.md
HBEXEC_WIDE -- requirements
Module: hbexec_wide

Interface
REQ-001 SHALL have parameter AW, default 30: wishbone word-address width; AW <= DW-1.
REQ-002 SHALL have parameter DW, default 32: bus data width, a multiple of 8; command and response words are DW+2 bits.
REQ-003 SHALL have parameter LGBURST, default 4: log2 of the maximum read burst length.
REQ-004 SHALL have the following ports:
- i_clk, in, 1: the single clock.
- i_reset, in, 1: reset, asynchronous and active-high.
- i_cmd_stb, in, 1: command word valid.
- i_cmd_word, in, DW+2: command word.
- o_cmd_busy, out, 1: command not accepted this cycle.
- o_rsp_stb, out, 1: response word valid; a single-cycle pulse.
- o_rsp_word, out, DW+2: response word.
- o_wb_cyc, o_wb_stb, o_wb_we, out, 1 each: wishbone master controls.
- o_wb_addr, out, AW: wishbone address.
- o_wb_data, out, DW: wishbone write data.
- o_wb_sel, out, DW/8: wishbone byte selects.
- i_wb_ack, i_wb_stall, i_wb_err, in, 1 each: wishbone slave responses.
- i_wb_data, in, DW: wishbone read data.

Function
REQ-005 A command SHALL be accepted on the cycle in which i_cmd_stb is high and o_cmd_busy is low.
REQ-006 Command type is i_cmd_word[DW+1:DW], decoded as follows:
- 00: read; [LGBURST-1:0] holds count-1.
- 01: write; [DW-1:0] holds the data.
- 10: set address; [AW-1:0] holds the address, and bit [DW-1]=1 selects a fixed (non-incrementing) address.
- 11: ignored.
REQ-007 A set-address command SHALL load the address register and the increment flag, and SHALL emit {2'b10, zero-extended address} on the next cycle without starting a bus cycle.
REQ-008 The state machine SHALL have three states: IDLE, REQ (o_wb_stb high) and WAIT (acknowledgements outstanding, o_wb_stb low).
REQ-009 A read or write command accepted in cycle N SHALL raise o_wb_cyc and o_wb_stb in cycle N+1.
REQ-010 o_wb_sel SHALL be all ones.
REQ-011 o_wb_we SHALL be high for writes only.
REQ-012 In REQ, each cycle with !i_wb_stall SHALL count one request as issued.
REQ-013 The address SHALL advance by 1 per issued request unless the fixed flag is set; the address wraps modulo 2^AW.
REQ-014 When the last request issues, the block SHALL go to WAIT, or directly to IDLE if every acknowledgement has already arrived.
REQ-015 Each i_wb_ack on a read SHALL produce {2'b00, i_wb_data} on o_rsp_word on the following cycle.
REQ-016 Each i_wb_ack on a write SHALL produce {2'b01, DW'h0} on the following cycle.
REQ-017 An outstanding-acknowledgement counter (LGBURST+1 bits) SHALL track requests issued but not yet acknowledged; an issue and an acknowledgement in the same cycle leave it unchanged.
REQ-018 When the final acknowledgement arrives, o_wb_cyc SHALL drop in the same edge's update, and the state SHALL return to IDLE.
REQ-019 On i_wb_err while o_wb_cyc is high, the block SHALL:
- drop o_wb_cyc and o_wb_stb next cycle;
- discard the remaining burst and the outstanding count;
- emit {2'b11, DW'h0};
- return to IDLE.
REQ-020 o_cmd_busy SHALL be high whenever the state is not IDLE, and during the cycle in which a response from the final acknowledgement or an error is being emitted.
REQ-021 Responses SHALL NOT be backpressured; the downstream stage accepts every o_rsp_stb.
REQ-022 i_wb_ack and i_wb_err arriving while o_wb_cyc is low SHALL be ignored.

Reset
REQ-023 While i_reset is high, the following SHALL be 0:
- o_wb_cyc, o_wb_stb, o_wb_we and o_rsp_stb;
- the counters;
- the address and the increment flag (increment enabled);
- the state (IDLE).
REQ-024 On the first clock after i_reset deasserts, the block SHALL emit a single reset response {2'b11, DW'h1}.
REQ-025 A reset asserted mid-burst SHALL abort the cycle immediately (asynchronously), with no error response.

Configuration
REQ-026 The macro HBEXEC_WIDE_BURST_EN SHALL control read bursts.
- Defined: a read command issues count = [LGBURST-1:0]+1 pipelined requests within one o_wb_cyc.
- Undefined: the count field is ignored, every read is a single request, and the counters reduce to a single pending flag.

Structure
REQ-027 A shared package hbexec_wide_pkg SHALL hold:
- the command and response type codes (CMD_RD, CMD_WR, CMD_ADDR, RSP_RD, RSP_WR, RSP_ADDR, RSP_SPECIAL);
- the state enumeration;
- the reset and error special-payload constants.
REQ-028 One sub-module, hbexec_wide_rsp, SHALL form and register the response word and o_rsp_stb from the acknowledge, error, address and reset events.

Verification
REQ-029 The bench SHALL cover at least the following directed scenarios:
- Set address 0x100 then write 0xDEADBEEF: response {10,0x100}, then a single write at 0x100 with sel=F, response {01,0}, and the next address is 0x101.
- Burst read count=4 with the stall high on the 2nd request and acks with latency 3: four requests at 0x101..0x104, responses {00,data} in order, o_wb_cyc low after the 4th ack, and the increment respected.
- Fixed-address bit set at 0x20, burst of 3: all three requests at 0x20.
- Error on the 2nd ack of a burst of 8: o_wb_cyc low next cycle, a single {11,0} response, no further read responses, and a command accepted afterwards.
- Reset asserted mid-burst: outputs immediately 0; after release exactly one {11,1} response.
- Without HBEXEC_WIDE_BURST_EN, a read with count field 7: exactly one request and one response.
